// File: rtl/dispatch_unit_pkg.sv
// Shared types and constants for the dispatch stage: ROB sizing, optype codes,
// the held instruction and the issue packet.
package dispatch_unit_pkg;

  localparam int unsigned RobSz = 16;
  localparam int unsigned TagW  = $clog2(RobSz) + 1;

  typedef logic [TagW-1:0] tag_t;

  typedef enum logic [3:0] {
    OptAlu = 4'd0,
    OptLad = 4'd1,
    OptStr = 4'd2
  } optype_e;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [3:0]  optype;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
  } instr_t;

  typedef struct packed {
    logic [31:0] vj;
    logic [31:0] vk;
    tag_t        qj;
    tag_t        qk;
    logic [3:0]  opcode;
    logic [3:0]  optype;
    tag_t        dest;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
  } issue_t;

  function automatic logic is_mem_op(logic [3:0] optype);
    return (optype == 4'(OptLad)) || (optype == 4'(OptStr));
  endfunction

  // Tags run 1..RobSz; 0 is reserved for "value ready".
  function automatic tag_t tag_next(tag_t t);
    return (t == tag_t'(RobSz)) ? tag_t'(1) : t + tag_t'(1);
  endfunction

endpackage

// File: rtl/dispatch_unit_if.sv
// Bundle of every dispatch-stage signal except clock and reset; master is the
// dispatch side, slave is the surrounding IQ/RF/ROB/RS/LSB/CDB environment.
interface dispatch_unit_if;
  import dispatch_unit_pkg::*;

  logic        rdy;
  logic        reset;
  logic        iq_valid;
  logic        iq_ready;
  logic [3:0]  iq_opcode;
  logic [3:0]  iq_optype;
  logic [4:0]  iq_rs1;
  logic [4:0]  iq_rs2;
  logic [4:0]  iq_rd;
  logic [31:0] iq_imm;
  logic [31:0] iq_pc;
  logic [4:0]  rf_rs1_idx;
  logic [4:0]  rf_rs2_idx;
  logic [31:0] rf_val1;
  logic [31:0] rf_val2;
  tag_t        rf_tag1;
  tag_t        rf_tag2;
  tag_t        rob_q1_tag;
  tag_t        rob_q2_tag;
  logic        rob_q1_rdy;
  logic        rob_q2_rdy;
  logic [31:0] rob_q1_val;
  logic [31:0] rob_q2_val;
  logic        rob_full;
  logic        rs_full;
  logic        lsb_full;
  logic        alu_valid;
  tag_t        alu_tag;
  logic [31:0] alu_res;
  logic        lad_valid;
  tag_t        lad_tag;
  logic [31:0] lad_res;
  logic        run_add;
  logic        run_lsb;
  logic        rob_alloc;
  logic [31:0] out_Vj;
  logic [31:0] out_Vk;
  tag_t        out_Qj;
  tag_t        out_Qk;
  logic [3:0]  out_opcode;
  logic [3:0]  out_optype;
  tag_t        out_Dest;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic        ren_en;
  logic [4:0]  ren_rd;
  tag_t        ren_tag;

  modport master (
    input  rdy, reset, iq_valid, iq_opcode, iq_optype, iq_rs1, iq_rs2, iq_rd, iq_imm, iq_pc,
           rf_val1, rf_val2, rf_tag1, rf_tag2, rob_q1_rdy, rob_q2_rdy, rob_q1_val, rob_q2_val,
           rob_full, rs_full, lsb_full, alu_valid, alu_tag, alu_res, lad_valid, lad_tag, lad_res,
    output iq_ready, rf_rs1_idx, rf_rs2_idx, rob_q1_tag, rob_q2_tag, run_add, run_lsb, rob_alloc,
           out_Vj, out_Vk, out_Qj, out_Qk, out_opcode, out_optype, out_Dest, out_pc, out_imm,
           out_rd, ren_en, ren_rd, ren_tag
  );

  modport slave (
    output rdy, reset, iq_valid, iq_opcode, iq_optype, iq_rs1, iq_rs2, iq_rd, iq_imm, iq_pc,
           rf_val1, rf_val2, rf_tag1, rf_tag2, rob_q1_rdy, rob_q2_rdy, rob_q1_val, rob_q2_val,
           rob_full, rs_full, lsb_full, alu_valid, alu_tag, alu_res, lad_valid, lad_tag, lad_res,
    input  iq_ready, rf_rs1_idx, rf_rs2_idx, rob_q1_tag, rob_q2_tag, run_add, run_lsb, rob_alloc,
           out_Vj, out_Vk, out_Qj, out_Qk, out_opcode, out_optype, out_Dest, out_pc, out_imm,
           out_rd, ren_en, ren_rd, ren_tag
  );

endinterface

// File: rtl/dispatch_unit_operand_resolve.sv
// Resolves one source operand to a value or a producer tag from the last
// rename, the register file, the ROB and both CDB snoop ports.
module dispatch_unit_operand_resolve
  import dispatch_unit_pkg::*;
(
  input  logic [4:0]  idx_i,
  input  logic        byp_v_i,
  input  logic [4:0]  byp_rd_i,
  input  tag_t        byp_tag_i,
  input  logic [31:0] rf_val_i,
  input  tag_t        rf_tag_i,
  input  logic        rob_rdy_i,
  input  logic [31:0] rob_val_i,
  input  logic        alu_valid_i,
  input  tag_t        alu_tag_i,
  input  logic [31:0] alu_res_i,
  input  logic        lad_valid_i,
  input  tag_t        lad_tag_i,
  input  logic [31:0] lad_res_i,
  output logic [31:0] val_o,
  output tag_t        tag_o
);

  always_comb begin
    val_o = '0;
    tag_o = '0;
    if (idx_i != '0) begin
      // The RF has not yet absorbed the rename issued last cycle.
      if (byp_v_i && (byp_rd_i == idx_i)) begin
        tag_o = byp_tag_i;
      end else if (rf_tag_i == '0) begin
        val_o = rf_val_i;
      end else if (rob_rdy_i) begin
        val_o = rob_val_i;
      end else begin
        tag_o = rf_tag_i;
      end
    end
    if ((tag_o != '0) && alu_valid_i && (alu_tag_i == tag_o)) begin
      val_o = alu_res_i;
      tag_o = '0;
    end else if ((tag_o != '0) && lad_valid_i && (lad_tag_i == tag_o)) begin
      val_o = lad_res_i;
      tag_o = '0;
    end
  end

endmodule

// File: rtl/dispatch_unit.sv
// Dispatch stage: holds one decoded instruction, renames rd to a ROB tag,
// resolves rs1/rs2 and issues a registered packet to the RS or the LSB.
module dispatch_unit
  import dispatch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  dispatch_unit_if.master bus_io
);

  logic   hold_v_q, hold_v_d;
  instr_t hold_q, hold_d;
  tag_t   next_tag_q, next_tag_d;
  logic   run_add_q, run_add_d;
  logic   run_lsb_q, run_lsb_d;
  logic   rob_alloc_q, rob_alloc_d;
  logic   ren_en_q, ren_en_d;
  logic [4:0] ren_rd_q, ren_rd_d;
  tag_t   ren_tag_q, ren_tag_d;
  issue_t pkt_q, pkt_d;

  logic        mem_op, tgt_full, fire, iq_take;
  logic [31:0] vj, vk;
  tag_t        qj, qk;

  assign bus_io.rf_rs1_idx = hold_q.rs1;
  assign bus_io.rf_rs2_idx = hold_q.rs2;
  assign bus_io.rob_q1_tag = bus_io.rf_tag1;
  assign bus_io.rob_q2_tag = bus_io.rf_tag2;

  // The rename register doubles as the last-rename bypass: both clear on any non-issue cycle.
  dispatch_unit_operand_resolve u_res_j (
    .idx_i       (hold_q.rs1),
    .byp_v_i     (ren_en_q),
    .byp_rd_i    (ren_rd_q),
    .byp_tag_i   (ren_tag_q),
    .rf_val_i    (bus_io.rf_val1),
    .rf_tag_i    (bus_io.rf_tag1),
    .rob_rdy_i   (bus_io.rob_q1_rdy),
    .rob_val_i   (bus_io.rob_q1_val),
    .alu_valid_i (bus_io.alu_valid),
    .alu_tag_i   (bus_io.alu_tag),
    .alu_res_i   (bus_io.alu_res),
    .lad_valid_i (bus_io.lad_valid),
    .lad_tag_i   (bus_io.lad_tag),
    .lad_res_i   (bus_io.lad_res),
    .val_o       (vj),
    .tag_o       (qj)
  );

  dispatch_unit_operand_resolve u_res_k (
    .idx_i       (hold_q.rs2),
    .byp_v_i     (ren_en_q),
    .byp_rd_i    (ren_rd_q),
    .byp_tag_i   (ren_tag_q),
    .rf_val_i    (bus_io.rf_val2),
    .rf_tag_i    (bus_io.rf_tag2),
    .rob_rdy_i   (bus_io.rob_q2_rdy),
    .rob_val_i   (bus_io.rob_q2_val),
    .alu_valid_i (bus_io.alu_valid),
    .alu_tag_i   (bus_io.alu_tag),
    .alu_res_i   (bus_io.alu_res),
    .lad_valid_i (bus_io.lad_valid),
    .lad_tag_i   (bus_io.lad_tag),
    .lad_res_i   (bus_io.lad_res),
    .val_o       (vk),
    .tag_o       (qk)
  );

  // Last cycle's issue pulse covers a full flag that has not caught up yet.
  assign mem_op   = is_mem_op(hold_q.optype);
  assign tgt_full = mem_op ? (bus_io.lsb_full | run_lsb_q) : (bus_io.rs_full | run_add_q);
  assign fire     = hold_v_q & ~bus_io.rob_full & ~rob_alloc_q & ~tgt_full;
  assign iq_take  = bus_io.iq_valid & bus_io.iq_ready;

  assign bus_io.iq_ready = ~hold_v_q | fire;

  always_comb begin
    hold_v_d    = hold_v_q;
    hold_d      = hold_q;
    next_tag_d  = next_tag_q;
    run_add_d   = run_add_q;
    run_lsb_d   = run_lsb_q;
    rob_alloc_d = rob_alloc_q;
    ren_en_d    = ren_en_q;
    ren_rd_d    = ren_rd_q;
    ren_tag_d   = ren_tag_q;
    pkt_d       = pkt_q;
    if (bus_io.rdy) begin
      if (bus_io.reset) begin
        hold_v_d    = 1'b0;
        next_tag_d  = tag_t'(1);
        run_add_d   = 1'b0;
        run_lsb_d   = 1'b0;
        rob_alloc_d = 1'b0;
        ren_en_d    = 1'b0;
      end else begin
        run_add_d   = fire & ~mem_op;
        run_lsb_d   = fire & mem_op;
        rob_alloc_d = fire;
        ren_en_d    = fire & (hold_q.rd != '0);
        if (fire) begin
          pkt_d = '{vj: vj, vk: vk, qj: qj, qk: qk, opcode: hold_q.opcode,
                    optype: hold_q.optype, dest: next_tag_q, pc: hold_q.pc,
                    imm: hold_q.imm, rd: hold_q.rd};
          next_tag_d = tag_next(next_tag_q);
          hold_v_d   = 1'b0;
          if (hold_q.rd != '0) begin
            ren_rd_d  = hold_q.rd;
            ren_tag_d = next_tag_q;
          end
        end
        if (iq_take) begin
          hold_v_d = 1'b1;
          hold_d   = '{opcode: bus_io.iq_opcode, optype: bus_io.iq_optype, rs1: bus_io.iq_rs1,
                       rs2: bus_io.iq_rs2, rd: bus_io.iq_rd, imm: bus_io.iq_imm,
                       pc: bus_io.iq_pc};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_q    <= 1'b0;
      hold_q      <= '0;
      next_tag_q  <= tag_t'(1);
      run_add_q   <= 1'b0;
      run_lsb_q   <= 1'b0;
      rob_alloc_q <= 1'b0;
      ren_en_q    <= 1'b0;
      ren_rd_q    <= '0;
      ren_tag_q   <= '0;
      pkt_q       <= '0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_q      <= hold_d;
      next_tag_q  <= next_tag_d;
      run_add_q   <= run_add_d;
      run_lsb_q   <= run_lsb_d;
      rob_alloc_q <= rob_alloc_d;
      ren_en_q    <= ren_en_d;
      ren_rd_q    <= ren_rd_d;
      ren_tag_q   <= ren_tag_d;
      pkt_q       <= pkt_d;
    end
  end

  assign bus_io.run_add    = run_add_q;
  assign bus_io.run_lsb    = run_lsb_q;
  assign bus_io.rob_alloc  = rob_alloc_q;
  assign bus_io.ren_en     = ren_en_q;
  assign bus_io.ren_rd     = ren_rd_q;
  assign bus_io.ren_tag    = ren_tag_q;
  assign bus_io.out_Vj     = pkt_q.vj;
  assign bus_io.out_Vk     = pkt_q.vk;
  assign bus_io.out_Qj     = pkt_q.qj;
  assign bus_io.out_Qk     = pkt_q.qk;
  assign bus_io.out_opcode = pkt_q.opcode;
  assign bus_io.out_optype = pkt_q.optype;
  assign bus_io.out_Dest   = pkt_q.dest;
  assign bus_io.out_pc     = pkt_q.pc;
  assign bus_io.out_imm    = pkt_q.imm;
  assign bus_io.out_rd     = pkt_q.rd;

endmodule

// File: tb/tb_dispatch_unit.sv
// Bench for dispatch_unit: a small RF/ROB environment, an instruction-level
// reference model checked every cycle, and directed scenarios with literal checks.
module tb_dispatch_unit;
  import dispatch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dispatch_unit_if bus ();

  dispatch_unit dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  // Environment: register file with rename tags, ROB completion table.
  logic [31:0] rf_val [32];
  tag_t        rf_tag [32];
  logic        rob_done [32];
  logic [31:0] rob_val [32];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_val[i] <= 32'h100 + 32'(i);
        rf_tag[i] <= '0;
      end
      rf_tag[6]  <= tag_t'(7);
      rf_tag[9]  <= tag_t'(3);
      rf_tag[10] <= tag_t'(4);
      rf_tag[12] <= tag_t'(5);
    end else if (bus.ren_en) begin
      rf_tag[bus.ren_rd] <= bus.ren_tag;
    end
  end

  assign bus.rf_val1    = rf_val[bus.rf_rs1_idx];
  assign bus.rf_val2    = rf_val[bus.rf_rs2_idx];
  assign bus.rf_tag1    = rf_tag[bus.rf_rs1_idx];
  assign bus.rf_tag2    = rf_tag[bus.rf_rs2_idx];
  assign bus.rob_q1_rdy = rob_done[bus.rob_q1_tag];
  assign bus.rob_q2_rdy = rob_done[bus.rob_q2_tag];
  assign bus.rob_q1_val = rob_val[bus.rob_q1_tag];
  assign bus.rob_q2_val = rob_val[bus.rob_q2_tag];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the instruction waiting to issue, the issue it made last
  // cycle, and the packet that issue must have produced.
  instr_t      m_hold;
  bit          m_hold_v;
  int          m_next;
  bit          m_add, m_lsb, m_alloc, m_ren;
  int          m_ren_rd, m_ren_tag;
  logic [31:0] e_vj, e_vk, e_pc, e_imm;
  int          e_qj, e_qk, e_dest, e_opc, e_opt, e_rd;

  function automatic bit model_can_issue();
    bit to_lsb, unit_busy;
    to_lsb    = (m_hold.optype == 4'd1) || (m_hold.optype == 4'd2);
    unit_busy = to_lsb ? (bus.lsb_full || m_lsb) : (bus.rs_full || m_add);
    return m_hold_v && !bus.rob_full && !m_alloc && !unit_busy;
  endfunction

  function automatic void model_operand(input int idx, output logic [31:0] v, output int q);
    int t;
    v = '0;
    q = 0;
    if (idx == 0) return;
    t = int'(rf_tag[idx]);
    if (m_ren && m_ren_rd == idx) q = m_ren_tag;
    else if (t == 0) v = rf_val[idx];
    else if (rob_done[t]) v = rob_val[t];
    else q = t;
    if (q != 0 && bus.alu_valid && int'(bus.alu_tag) == q) begin
      v = bus.alu_res;
      q = 0;
    end else if (q != 0 && bus.lad_valid && int'(bus.lad_tag) == q) begin
      v = bus.lad_res;
      q = 0;
    end
  endfunction

  // Advance the model over the coming clock edge, using the inputs presented now.
  task automatic model_step();
    bit go, take, to_lsb;
    if (rst) begin
      m_hold_v = 0; m_next = 1; m_add = 0; m_lsb = 0; m_alloc = 0; m_ren = 0;
      m_ren_rd = 0; m_ren_tag = 0; m_hold = '0;
      e_vj = 0; e_vk = 0; e_qj = 0; e_qk = 0; e_opc = 0; e_opt = 0; e_dest = 0;
      e_pc = 0; e_imm = 0; e_rd = 0;
      return;
    end
    if (!bus.rdy) return;
    if (bus.reset) begin
      m_hold_v = 0; m_next = 1; m_add = 0; m_lsb = 0; m_alloc = 0; m_ren = 0;
      return;
    end
    go     = model_can_issue();
    take   = bus.iq_valid && (!m_hold_v || go);
    to_lsb = (m_hold.optype == 4'd1) || (m_hold.optype == 4'd2);
    if (go) begin
      model_operand(int'(m_hold.rs1), e_vj, e_qj);
      model_operand(int'(m_hold.rs2), e_vk, e_qk);
      e_opc  = int'(m_hold.opcode);
      e_opt  = int'(m_hold.optype);
      e_pc   = m_hold.pc;
      e_imm  = m_hold.imm;
      e_rd   = int'(m_hold.rd);
      e_dest = m_next;
      m_next = (m_next == RobSz) ? 1 : m_next + 1;
    end
    m_add   = go && !to_lsb;
    m_lsb   = go && to_lsb;
    m_alloc = go;
    m_ren   = go && (m_hold.rd != 0);
    if (m_ren) begin
      m_ren_rd  = int'(m_hold.rd);
      m_ren_tag = e_dest;
    end
    if (go) m_hold_v = 0;
    if (take) begin
      m_hold_v      = 1;
      m_hold.opcode = bus.iq_opcode;
      m_hold.optype = bus.iq_optype;
      m_hold.rs1    = bus.iq_rs1;
      m_hold.rs2    = bus.iq_rs2;
      m_hold.rd     = bus.iq_rd;
      m_hold.imm    = bus.iq_imm;
      m_hold.pc     = bus.iq_pc;
    end
  endtask

  task automatic compare();
    if (rst) return;
    chk("run_add", 32'(bus.run_add), 32'(m_add));
    chk("run_lsb", 32'(bus.run_lsb), 32'(m_lsb));
    chk("rob_alloc", 32'(bus.rob_alloc), 32'(m_alloc));
    chk("ren_en", 32'(bus.ren_en), 32'(m_ren));
    chk("iq_ready", 32'(bus.iq_ready), 32'(!m_hold_v || model_can_issue()));
    if (m_ren) begin
      chk("ren_rd", 32'(bus.ren_rd), 32'(m_ren_rd));
      chk("ren_tag", 32'(bus.ren_tag), 32'(m_ren_tag));
    end
    if (m_add || m_lsb) begin
      chk("out_Vj", bus.out_Vj, e_vj);
      chk("out_Vk", bus.out_Vk, e_vk);
      chk("out_Qj", 32'(bus.out_Qj), 32'(e_qj));
      chk("out_Qk", 32'(bus.out_Qk), 32'(e_qk));
      chk("out_opcode", 32'(bus.out_opcode), 32'(e_opc));
      chk("out_optype", 32'(bus.out_optype), 32'(e_opt));
      chk("out_Dest", 32'(bus.out_Dest), 32'(e_dest));
      chk("out_pc", bus.out_pc, e_pc);
      chk("out_imm", bus.out_imm, e_imm);
      chk("out_rd", 32'(bus.out_rd), 32'(e_rd));
    end
  endtask

  // One clock: check and step the model at negedge, return just after posedge.
  task automatic cyc();
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] opc, input logic [3:0] opt, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                      input logic [31:0] pc);
    bit took = 0;
    bus.iq_opcode = opc; bus.iq_optype = opt; bus.iq_rs1 = rs1; bus.iq_rs2 = rs2;
    bus.iq_rd = rd; bus.iq_imm = imm; bus.iq_pc = pc; bus.iq_valid = 1'b1;
    for (int i = 0; i < 40 && !took; i++) begin
      #1;
      took = bus.iq_ready;
      cyc();
    end
    bus.iq_valid = 1'b0;
    chk("push_accepted", 32'(took), 32'd1);
  endtask

  task automatic wait_issue(input string name);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      seen = bus.run_add | bus.run_lsb;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic flush();
    bus.reset = 1'b1;
    cyc();
    bus.reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rob_done[i] = 1'b0;
      rob_val[i]  = '0;
    end
    rob_done[5] = 1'b1;
    rob_val[5]  = 32'hABC;
    bus.rdy = 1'b1; bus.reset = 1'b0; bus.iq_valid = 1'b0;
    bus.iq_opcode = '0; bus.iq_optype = '0; bus.iq_rs1 = '0; bus.iq_rs2 = '0; bus.iq_rd = '0;
    bus.iq_imm = '0; bus.iq_pc = '0;
    bus.rob_full = 1'b0; bus.rs_full = 1'b0; bus.lsb_full = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_tag = '0; bus.alu_res = '0;
    bus.lad_valid = 1'b0; bus.lad_tag = '0; bus.lad_res = '0;

    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_iq_ready", 32'(bus.iq_ready), 32'd1);
    chk("rst_run_add", 32'(bus.run_add), 32'd0);
    chk("rst_rob_alloc", 32'(bus.rob_alloc), 32'd0);
    chk("rst_out_Dest", 32'(bus.out_Dest), 32'd0);
    chk("rst_out_Vj", bus.out_Vj, 32'd0);

    // Independent ADD x1 = x2 + x3 issues one cycle after the IQ pop.
    push(4'h3, OptAlu, 5'd2, 5'd3, 5'd1, 32'd0, 32'h40);
    cyc();
    chk("t1_run_add", 32'(bus.run_add), 32'd1);
    chk("t1_Dest", 32'(bus.out_Dest), 32'd1);
    chk("t1_Vj", bus.out_Vj, 32'h102);
    chk("t1_Vk", bus.out_Vk, 32'h103);
    chk("t1_Qj", 32'(bus.out_Qj), 32'd0);
    chk("t1_ren_rd", 32'(bus.ren_rd), 32'd1);
    chk("t1_ren_tag", 32'(bus.ren_tag), 32'd1);
    flush();

    // ADD x6 then ADDI x4 = x6 + 5: x6 carries a stale tag 7 before the rename.
    push(4'h3, OptAlu, 5'd2, 5'd3, 5'd6, 32'd0, 32'h80);
    push(4'h4, OptAlu, 5'd6, 5'd0, 5'd4, 32'd5, 32'h84);
    chk("t2a_Dest", 32'(bus.out_Dest), 32'd1);
    cyc();
    chk("t2_guard_run_add", 32'(bus.run_add), 32'd0);
    cyc();
    chk("t2b_run_add", 32'(bus.run_add), 32'd1);
    chk("t2b_Dest", 32'(bus.out_Dest), 32'd2);
    chk("t2b_Qj", 32'(bus.out_Qj), 32'd1);
    chk("t2b_imm", bus.out_imm, 32'd5);
    flush();

    // CDB snoop on both sources in the issue cycle.
    push(4'h3, OptAlu, 5'd9, 5'd10, 5'd7, 32'd0, 32'hC0);
    bus.alu_valid = 1'b1; bus.alu_tag = tag_t'(3); bus.alu_res = 32'h55;
    bus.lad_valid = 1'b1; bus.lad_tag = tag_t'(4); bus.lad_res = 32'h66;
    cyc();
    bus.alu_valid = 1'b0; bus.lad_valid = 1'b0;
    chk("t3_Vj", bus.out_Vj, 32'h55);
    chk("t3_Qj", 32'(bus.out_Qj), 32'd0);
    chk("t3_Vk", bus.out_Vk, 32'h66);
    // Completed ROB entry gives a value; a pending one gives its tag.
    push(4'h3, OptAlu, 5'd12, 5'd9, 5'd13, 32'd0, 32'hC4);
    wait_issue("t3b_issue");
    chk("t3b_Vj", bus.out_Vj, 32'hABC);
    chk("t3b_Qk", 32'(bus.out_Qk), 32'd3);
    flush();

    // Load stalled by a full LSB.
    bus.lsb_full = 1'b1;
    push(4'h5, OptLad, 5'd2, 5'd0, 5'd8, 32'd8, 32'h100);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t4_stall_run_lsb", 32'(bus.run_lsb), 32'd0);
      chk("t4_stall_iq_ready", 32'(bus.iq_ready), 32'd0);
    end
    bus.lsb_full = 1'b0;
    cyc();
    chk("t4_run_lsb", 32'(bus.run_lsb), 32'd1);
    chk("t4_Vj", bus.out_Vj, 32'h102);

    // Store with rd = x0 and rs1 = x0, then freeze with rdy low.
    push(4'h6, OptStr, 5'd0, 5'd2, 5'd0, 32'd4, 32'h104);
    wait_issue("t6_issue");
    chk("t6_run_lsb", 32'(bus.run_lsb), 32'd1);
    chk("t6_ren_en", 32'(bus.ren_en), 32'd0);
    chk("t6_Vj", bus.out_Vj, 32'd0);
    chk("t6_Qj", 32'(bus.out_Qj), 32'd0);
    chk("t6_Dest", 32'(bus.out_Dest), 32'd2);
    bus.rdy = 1'b0;
    cyc();
    cyc();
    chk("rdy_hold_run_lsb", 32'(bus.run_lsb), 32'd1);
    bus.rdy = 1'b1;
    cyc();
    chk("rdy_release_run_lsb", 32'(bus.run_lsb), 32'd0);
    flush();

    // Seventeen issues: the tag counter wraps back to 1.
    for (int k = 1; k <= 16; k++) push(4'h3, OptAlu, 5'd0, 5'd0, 5'd11, 32'd0, 32'(k * 4));
    push(4'h3, OptAlu, 5'd0, 5'd0, 5'd11, 32'd0, 32'(17 * 4));
    chk("t5_Dest16", 32'(bus.out_Dest), 32'd16);
    wait_issue("t5_issue17");
    chk("t5_Dest_wrap", 32'(bus.out_Dest), 32'd1);
    chk("t5_pc17", bus.out_pc, 32'(17 * 4));

    // ROB full stall, then a flush mid-stall.
    bus.rob_full = 1'b1;
    push(4'h3, OptAlu, 5'd0, 5'd0, 5'd11, 32'd0, 32'h400);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("robfull_run_add", 32'(bus.run_add), 32'd0);
    end
    flush();
    bus.rob_full = 1'b0;
    chk("flush_iq_ready", 32'(bus.iq_ready), 32'd1);
    cyc();
    chk("flush_no_issue", 32'(bus.run_add), 32'd0);
    push(4'h3, OptAlu, 5'd0, 5'd0, 5'd11, 32'd0, 32'h500);
    wait_issue("post_flush_issue");
    chk("post_flush_Dest", 32'(bus.out_Dest), 32'd1);
    chk("post_flush_pc", bus.out_pc, 32'h500);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
